ntt_coef_reader: RTL and testbench
==================================

NTT_COEF_READER -- requirements
Module: ntt_coef_reader

Interface
REQ-001 Parameter DATA_W, default 16: coefficient width in bits.
REQ-002 Parameter ADDR_W, default 8: RAM address width.
REQ-003 Parameter LEN, default 256: words per burst; 1 <= LEN <= 2^ADDR_W.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 start  in  1  burst request; sampled only in IDLE.
REQ-007 base  in  ADDR_W  first RAM address; latched when start is accepted.
REQ-008 ram_ren  out  1  RAM read enable.
REQ-009 ram_raddr  out  ADDR_W  RAM read address.
REQ-010 ram_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after the ram_ren cycle.
REQ-011 out_valid  out  1  stream word valid.
REQ-012 out_ready  in  1  downstream accept.
REQ-013 out_data  out  DATA_W  stream word.
REQ-014 out_last  out  1  marks word index LEN-1.
REQ-015 busy  out  1  high in READ and DRAIN.
REQ-016 done  out  1  one-cycle pulse at burst completion.

Function
REQ-017 The FSM shall have the states IDLE, READ and DRAIN.
- IDLE->READ: start=1; base is latched and issue/emit counters are cleared.
- READ->DRAIN: LEN reads issued.
- DRAIN->IDLE: LEN words handshaken.
REQ-018 A handshake shall occur on a cycle with out_valid=1 and out_ready=1; no other cycle transfers a word.
REQ-019 The k-th read (k=0..LEN-1) shall use ram_raddr = (base + k) mod 2^ADDR_W, so addresses wrap past 2^ADDR_W-1 to 0.
REQ-020 The block shall hold returned words in a 2-entry FIFO.
REQ-021 A read shall issue in READ only when occupancy + inflight - pop < 2.
- occupancy: words in the FIFO.
- inflight: a read issued the previous cycle.
- pop: a handshake this cycle.
- The FIFO therefore never overflows.
REQ-022 With out_ready held at 1, the block shall sustain one word per cycle after an initial 2-cycle latency (start accept -> first out_valid).
REQ-023 When out_ready=0, out_data and out_last shall remain stable while out_valid=1.
REQ-024 Words shall emerge in issue order.
REQ-025 out_last shall assert only on the word with index LEN-1.
REQ-026 done shall pulse high for exactly one cycle, the cycle after the handshake of the last word; the FSM is in IDLE that same cycle.
REQ-027 The earliest new start shall be accepted on the cycle done is high.
REQ-028 start while busy=1 shall be ignored, with no effect on base, counters or outputs.
REQ-029 ram_ren shall be 0 in IDLE and DRAIN; ram_raddr is don't-care while ram_ren=0.
REQ-030 For LEN=1, the burst shall be one read, one word with out_last=1, then done.

Reset
REQ-031 rst=1 shall asynchronously force the following, without waiting for clk:
- state IDLE;
- FIFO empty and inflight 0;
- counters 0;
- busy=0, done=0, out_valid=0, out_last=0, ram_ren=0, ram_raddr=0, out_data=0.
REQ-032 A RAM response arriving after a mid-burst reset shall be discarded.
REQ-033 After rst deasserts, the first accepted start shall begin a clean burst from word 0.

Verification
REQ-034 LEN=8, base=0x10, out_ready=1, RAM returns addr+0x100 -> out_data 0x110..0x117 on 8 consecutive cycles; out_last on 0x117; done the next cycle.
REQ-035 LEN=8, base=0xFA -> ram_raddr sequence FA,FB,FC,FD,FE,FF,00,01; data order matches.
REQ-036 LEN=8, out_ready toggling 1,0,0,1 -> no word lost, duplicated or changed while stalled; never more than 2 reads outstanding beyond handshakes; exactly 8 handshakes.
REQ-037 rst pulsed asynchronously (mid-cycle) after 3 handshakes -> all outputs 0 immediately; next start with base=0x20 yields 0x120..0x127.
REQ-038 start held high for the whole burst -> a single burst; a second burst begins only on the done cycle.
REQ-039 LEN=1, base=0xFF -> one read at 0xFF; one word with out_last=1; done pulses once.

Source files
------------

// File: rtl/ntt_coef_reader.sv
// Burst reader: streams LEN RAM words from a base address through
// a 2-entry skid FIFO onto a valid/ready output.
module ntt_coef_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     issue_cnt, emit_cnt;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;
  logic              done_q;
  logic              accept, issue, pop;
  logic              push, pop_fifo, last_hs;
  logic              space;

  // An empty FIFO forwards the returning word straight to the output.
  assign out_valid = (cnt != 2'd0) || inflight;
  assign out_data  = (cnt != 2'd0) ? mem[rd_ptr] :
                     (inflight ? ram_rdata : '0);
  assign out_last  = out_valid && (emit_cnt == LAST);

  assign pop      = out_valid && out_ready;
  assign pop_fifo = pop && (cnt != 2'd0);
  assign push     = inflight && !(pop && cnt == 2'd0);
  assign last_hs  = pop && (emit_cnt == LAST);

  assign space = ({1'b0, cnt} + {2'b0, inflight}) <
                 (3'd2 + {2'b0, pop});

  assign accept = (state == IDLE) && start;
  assign issue  = (state == READ) && space;

  assign ram_ren   = issue;
  assign ram_raddr = raddr_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (issue && issue_cnt == LAST)
                 state_nx = DRAIN;
      DRAIN:   if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      issue_cnt <= '0;
      emit_cnt  <= '0;
      raddr_q   <= '0;
    end else begin
      state  <= state_nx;
      done_q <= last_hs && (state == DRAIN);
      if (accept) begin
        issue_cnt <= '0;
        emit_cnt  <= '0;
        raddr_q   <= base;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CW'(1);
          raddr_q   <= raddr_q + ADDR_W'(1);
        end
        if (pop) emit_cnt <= emit_cnt + CW'(1);
      end
    end
  end

  // Clearing inflight on reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      inflight <= issue;
      if (push) begin
        mem[wr_ptr] <= ram_rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule

// File: tb/tb_ntt_coef_reader.sv
// Directed/randomized bench for ntt_coef_reader against a
// queue-based reference of the expected word stream.
module tb_ntt_coef_reader;

  localparam int LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base = '0;
  logic        ram_ren;
  logic [7:0]  ram_raddr;
  logic [15:0] ram_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        start1 = 1'b0;
  logic [7:0]  base1 = '0;
  logic        ren1;
  logic [7:0]  raddr1;
  logic [15:0] rdata1 = '0;
  logic        valid1;
  logic        ready1 = 1'b1;
  logic [15:0] data1;
  logic        last1;
  logic        busy1;
  logic        done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ntt_coef_reader #(.DATA_W(16), .ADDR_W(8), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  ntt_coef_reader #(.DATA_W(16), .ADDR_W(8), .LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base(base1),
    .ram_ren(ren1), .ram_raddr(raddr1),
    .ram_rdata(rdata1), .out_valid(valid1),
    .out_ready(ready1), .out_data(data1),
    .out_last(last1), .busy(busy1), .done(done1)
  );

  // RAM: word at address a holds 0x100 + a, one cycle latency.
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= 16'h100 + {8'h0, ram_raddr};
    if (ren1) rdata1 <= 16'h100 + {8'h0, raddr1};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_last"}, {31'b0, out_last}, 0);
    chk({tag, "_ren"}, {31'b0, ram_ren}, 0);
    chk({tag, "_raddr"}, {24'b0, ram_raddr}, 0);
    chk({tag, "_data"}, {16'b0, out_data}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1 pattern, 2: random ready
  task automatic run_burst(input logic [7:0] b, input int mode,
                           input bit hold, input int stop_hs);
    logic [15:0] exp_q[$];
    logic [15:0] pdata;
    logic        plast, pstall;
    logic [7:0]  a;
    int hs, nren, first_v, done_cyc, last_cyc;
    for (int k = 0; k < LEN; k++) begin
      a = b + 8'(k);
      exp_q.push_back(16'h100 + {8'h0, a});
    end
    hs = 0; nren = 0; first_v = -1;
    done_cyc = -1; last_cyc = -1; pstall = 0;
    pdata = '0; plast = 0;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (!hold) start = 1'b0;
        base = 8'($urandom);
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (out_valid && first_v < 0) first_v = cyc;
      if (pstall) begin
        chk("stall_valid", {31'b0, out_valid}, 1);
        chk("stall_data", {16'b0, out_data}, {16'b0, pdata});
        chk("stall_last", {31'b0, out_last}, {31'b0, plast});
      end
      if (ram_ren) begin
        a = b + 8'(nren);
        chk("raddr", {24'b0, ram_raddr}, {24'b0, a});
        nren++;
      end
      if (out_valid) begin
        chk("last_flag", {31'b0, out_last},
            {31'b0, (hs == LEN - 1)});
        if (out_ready) begin
          chk("data", {16'b0, out_data}, {16'b0, exp_q[hs]});
          hs++;
          last_cyc = cyc;
        end
      end
      chk("outstanding", {31'b0, (nren - hs) <= 2}, 1);
      pstall = out_valid && !out_ready;
      pdata  = out_data;
      plast  = out_last;
      if (stop_hs >= 0 && hs == stop_hs) return;
      if (done) begin
        done_cyc = cyc;
        chk("done_idle", {31'b0, busy}, 0);
        break;
      end
    end
    chk("done_seen", {31'b0, done_cyc >= 0}, 1);
    chk("first_valid", first_v, 2);
    chk("reads", nren, LEN);
    chk("handshakes", hs, LEN);
    chk("done_timing", done_cyc, last_cyc + 1);
    if (mode == 0) chk("sustain", done_cyc, LEN + 2);
    if (hold) begin
      @(negedge clk);
      #1;
      chk("restart_busy", {31'b0, busy}, 1);
      chk("restart_done", {31'b0, done}, 0);
      start = 1'b0;
    end
  endtask

  initial begin
    int n1, h1, d1;
    logic [7:0] a1;
    logic [15:0] dd1;
    logic l1;
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_burst(8'h10, 0, 0, -1);
    run_burst(8'hFA, 0, 0, -1);
    run_burst(8'($urandom), 1, 0, -1);
    run_burst(8'($urandom), 2, 0, -1);

    run_burst(8'h40, 0, 0, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_burst(8'h20, 0, 0, -1);

    run_burst(8'($urandom), 2, 1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    n1 = 0; h1 = 0; d1 = 0;
    a1 = '0; dd1 = '0; l1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    base1  = 8'hFF;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start1 = 1'b0;
      end
      #1;
      if (ren1) begin
        n1++;
        a1 = raddr1;
      end
      if (valid1) begin
        h1++;
        dd1 = data1;
        l1  = last1;
      end
      if (done1) d1++;
    end
    chk("len1_reads", n1, 1);
    chk("len1_addr", {24'b0, a1}, 32'hFF);
    chk("len1_words", h1, 1);
    chk("len1_data", {16'b0, dd1}, 32'h1FF);
    chk("len1_last", {31'b0, l1}, 1);
    chk("len1_done", d1, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
